i_set_profile_gen: RTL and testbench

//  Parametrised successor to the discharge-current setpoint generator. On a start pulse it latches
//  the peak current, on-time and slopes, then plays one current profile (rectangle, triangle,

---
 rtl/i_set_pkg.sv | 13 +
 rtl/i_set_ramp_step.sv | 17 +
 rtl/i_set_profile_gen.sv | 144 ++++++++++++++
 tb/tb_i_set_profile_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/i_set_pkg.sv
// i_set_pkg: waveform codes and FSM state encoding shared by the current profile generator.
package i_set_pkg;
    localparam logic [15:0] WAVE_NONE = 16'h0000;
    localparam logic [15:0] WAVE_RECT = 16'h0002;
    localparam logic [15:0] WAVE_TRI  = 16'h0004;
    localparam logic [15:0] WAVE_TRAP = 16'h0008;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        FALL = 2'd3
    } state_t;
endpackage

// File: rtl/i_set_ramp_step.sv
// i_set_ramp_step: saturating add-to-limit (rise) or subtract-to-zero (fall), combinational.
module i_set_ramp_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] step,
    input  logic [W-1:0] limit,
    input  logic         down,
    output logic [W-1:0] nxt
);
    logic [W:0] sum;
    always_comb begin
        sum = {1'b0, cur} + {1'b0, step};
        nxt = down ? ((cur <= step) ? '0 : cur - step)
                   : ((sum >= {1'b0, limit}) ? limit : sum[W-1:0]);
    end
endmodule

// File: rtl/i_set_profile_gen.sv
// i_set_profile_gen: plays one RECT/TRI/TRAP current profile per start with busy/done/abort handshake.
// Defining I_SET_PULSE_CNT_EN adds the pulse_cnt port counting completed (non-aborted) profiles.
module i_set_profile_gen
    import i_set_pkg::*;
#(
    parameter int I_W    = 16,
    parameter int T_W    = 16,
    parameter int WAVE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WAVE_W-1:0] waveform,
    input  logic [I_W-1:0]    ip,
    input  logic [T_W-1:0]    ton,
    input  logic [I_W-1:0]    rise_step,
    input  logic [I_W-1:0]    fall_step,
    output logic [I_W-1:0]    i_set,
    output logic              busy,
`ifdef I_SET_PULSE_CNT_EN
    output logic [31:0]       pulse_cnt,
`endif
    output logic              done
);
    localparam logic [WAVE_W-1:0] W_RECT = WAVE_W'(WAVE_RECT);
    localparam logic [WAVE_W-1:0] W_TRI  = WAVE_W'(WAVE_TRI);
    localparam logic [WAVE_W-1:0] W_TRAP = WAVE_W'(WAVE_TRAP);

    state_t            state, state_n;
    logic [I_W-1:0]    ip_l, rise_l, fall_l, rise_eff, fall_eff;
    logic [I_W-1:0]    i_set_n, step_cur, step_amt, step_lim, ramp;
    logic [T_W-1:0]    ton_l, ton_eff, timer, timer_n;
    logic [WAVE_W-1:0] wave_l;
    logic              accept, at_peak, down, fall_go, done_n;

    always_comb begin
        accept   = state == IDLE && start && !abort;
        at_peak  = i_set == ip_l;
        down     = state == HOLD || state == FALL || (state == RISE && at_peak);
        ton_eff  = ton == '0 ? T_W'(1) : ton;
        rise_eff = rise_step == '0 ? I_W'(1) : rise_step;
        fall_eff = fall_step == '0 ? I_W'(1) : fall_step;
        // The first rise step is taken straight from the inputs so the profile starts one cycle after start.
        step_cur = state == IDLE ? '0 : i_set;
        step_amt = state == IDLE ? rise_eff : down ? fall_l : rise_l;
        step_lim = state == IDLE ? ip : ip_l;
    end

    i_set_ramp_step #(.W(I_W)) u_ramp (
        .cur  (step_cur),
        .step (step_amt),
        .limit(step_lim),
        .down (down),
        .nxt  (ramp)
    );

    always_comb begin
        state_n = state;
        i_set_n = i_set;
        timer_n = timer;
        done_n  = 1'b0;
        fall_go = 1'b0;
        if (abort && state != IDLE) begin
            state_n = IDLE;
            i_set_n = '0;
            done_n  = 1'b1;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (waveform == W_RECT) begin
                        state_n = HOLD;
                        i_set_n = ip;
                        timer_n = ton_eff - T_W'(1);
                    end else if (waveform == W_TRI || waveform == W_TRAP) begin
                        state_n = RISE;
                        i_set_n = ramp;
                    end else begin
                        done_n = 1'b1;
                    end
                end
                RISE: if (!at_peak) begin
                    i_set_n = ramp;
                end else if (wave_l == W_TRAP) begin
                    state_n = HOLD;
                    timer_n = ton_l - T_W'(1);
                end else begin
                    fall_go = 1'b1;
                end
                HOLD: if (timer != '0) begin
                    timer_n = timer - T_W'(1);
                end else if (wave_l == W_RECT) begin
                    state_n = IDLE;
                    i_set_n = '0;
                    done_n  = 1'b1;
                end else begin
                    fall_go = 1'b1;
                end
                FALL: fall_go = 1'b1;
            endcase
        end
        if (fall_go) begin
            i_set_n = ramp;
            state_n = ramp == '0 ? IDLE : FALL;
            done_n  = ramp == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            i_set  <= '0;
            timer  <= '0;
            done   <= 1'b0;
            ip_l   <= '0;
            ton_l  <= '0;
            rise_l <= '0;
            fall_l <= '0;
            wave_l <= '0;
        end else begin
            state <= state_n;
            i_set <= i_set_n;
            timer <= timer_n;
            done  <= done_n;
            if (accept) begin
                ip_l   <= ip;
                ton_l  <= ton_eff;
                rise_l <= rise_eff;
                fall_l <= fall_eff;
                wave_l <= waveform;
            end
        end
    end

    assign busy = state != IDLE;

`ifdef I_SET_PULSE_CNT_EN
    // A done raised from a running profile without abort is a completed profile.
    always_ff @(posedge clk) begin
        if (rst) pulse_cnt <= '0;
        else if (done_n && state != IDLE && !abort) pulse_cnt <= pulse_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_i_set_profile_gen.sv
// tb_i_set_profile_gen: directed table vectors plus hand-written long-profile and reset sequences.
module tb_i_set_profile_gen;
    import i_set_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] waveform, ip, ton, rise_step, fall_step, i_set;
    logic        busy, done;
`ifdef I_SET_PULSE_CNT_EN
    logic [31:0] pulse_cnt;
`endif
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       nm;
        logic        st;
        logic        ab;
        logic [15:0] wv, ipv, tn, rs, fs, ei;
        logic        eb, ed;
        int          cnt;
    } vec_t;
    vec_t tbl[$];

    i_set_profile_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .waveform (waveform),
        .ip       (ip),
        .ton      (ton),
        .rise_step(rise_step),
        .fall_step(fall_step),
        .i_set    (i_set),
        .busy     (busy),
`ifdef I_SET_PULSE_CNT_EN
        .pulse_cnt(pulse_cnt),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic void add(string nm, logic st, logic ab, logic [15:0] wv, logic [15:0] ipv,
                                logic [15:0] tn, logic [15:0] rs, logic [15:0] fs, logic [15:0] ei,
                                logic eb, logic ed, int cnt = -1);
        vec_t v;
        v.nm = nm; v.st = st; v.ab = ab; v.wv = wv; v.ipv = ipv; v.tn = tn; v.rs = rs; v.fs = fs;
        v.ei = ei; v.eb = eb; v.ed = ed; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    function automatic void idle(string nm, logic [15:0] ei, logic eb, logic ed, int cnt = -1);
        add(nm, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, ei, eb, ed, cnt);
    endfunction

    task automatic drive(input logic st, input logic ab, input logic [15:0] wv, input logic [15:0] ipv,
                         input logic [15:0] tn, input logic [15:0] rs, input logic [15:0] fs);
        start = st; abort = ab; waveform = wv; ip = ipv; ton = tn; rise_step = rs; fall_step = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] ei, input logic eb, input logic ed);
        n_vec++;
        if (i_set !== ei || busy !== eb || done !== ed) begin
            n_bad++;
            $display("FAIL %s: got i_set=%0d busy=%b done=%b, want i_set=%0d busy=%b done=%b",
                     nm, i_set, busy, done, ei, eb, ed);
        end
    endtask

    initial begin
        // TRAP ip=100 rise=30 fall=40 ton=5: 30,60,90,100 then 5 hold cycles of 100, then 60,20,0
        add("trap_start", 1, 0, WAVE_TRAP, 100, 5, 30, 40, 30, 1, 0);
        idle("trap_r60", 60, 1, 0);
        idle("trap_r90", 90, 1, 0);
        idle("trap_r100", 100, 1, 0);
        for (int k = 0; k < 5; k++) idle("trap_hold", 100, 1, 0);
        idle("trap_f60", 60, 1, 0);
        idle("trap_f20", 20, 1, 0);
        idle("trap_f0", 0, 0, 1);
        idle("trap_after", 0, 0, 0);
        // unknown code: no profile, done next cycle, completed count unchanged
        add("unk_start", 1, 0, 16'h8000, 55, 3, 1, 1, 0, 0, 1, 3);
        idle("unk_after", 0, 0, 0, 3);
        // TRI full-scale: no wrap on rise, single fall step to 0
        add("tri_max_start", 1, 0, WAVE_TRI, 16'hFFFF, 0, 40000, 16'hFFFF, 40000, 1, 0);
        idle("tri_max_sat", 16'hFFFF, 1, 0);
        idle("tri_max_fall", 0, 0, 1);
        idle("tri_max_after", 0, 0, 0);
        // abort in IDLE, and abort together with start: nothing happens
        add("abort_idle", 0, 1, WAVE_TRAP, 100, 5, 30, 40, 0, 0, 0);
        add("abort_w_start", 1, 1, WAVE_TRAP, 100, 5, 30, 40, 0, 0, 0);
        // TRAP aborted mid-hold with an ignored RECT start while busy
        add("ab_start", 1, 0, WAVE_TRAP, 100, 5, 30, 40, 30, 1, 0);
        idle("ab_r60", 60, 1, 0);
        add("ab_busy_start", 1, 0, WAVE_RECT, 500, 2, 1, 1, 90, 1, 0);
        idle("ab_r100", 100, 1, 0);
        for (int k = 0; k < 4; k++) idle("ab_hold", 100, 1, 0);
        add("ab_abort", 0, 1, 16'h0, 0, 0, 0, 0, 0, 0, 1);
        idle("ab_after1", 0, 0, 0);
        idle("ab_after2", 0, 0, 0);
        // back-to-back RECT: start in the done cycle, ton=0 behaves as 1
        add("b2b_start1", 1, 0, WAVE_RECT, 7, 2, 0, 0, 7, 1, 0);
        idle("b2b_hold1", 7, 1, 0);
        idle("b2b_done1", 0, 0, 1);
        add("b2b_start2", 1, 0, WAVE_RECT, 9, 0, 0, 0, 9, 1, 0);
        idle("b2b_done2", 0, 0, 1);
        idle("b2b_after", 0, 0, 0);
        // TRI ip=0: zero throughout
        add("ip0_start", 1, 0, WAVE_TRI, 0, 0, 5, 3, 0, 1, 0);
        idle("ip0_done", 0, 0, 1);
        idle("ip0_after", 0, 0, 0);
        // zero steps behave as 1
        add("step0_start", 1, 0, WAVE_TRI, 2, 0, 0, 0, 1, 1, 0);
        idle("step0_r2", 2, 1, 0);
        idle("step0_f1", 1, 1, 0);
        idle("step0_f0", 0, 0, 1);
        idle("step0_after", 0, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("reset", 0, 0, 0);
`ifdef I_SET_PULSE_CNT_EN
        n_vec++;
        if (pulse_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got pulse_cnt=%0d, want 0", pulse_cnt);
        end
`endif
        rst = 1'b0;

        // RECT ip=100 ton=4000
        drive(1, 0, WAVE_RECT, 100, 4000, 0, 0);
        check("rect_hold", 100, 1, 0);
        for (int k = 2; k <= 4000; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check("rect_hold", 100, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rect_done", 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rect_after", 0, 0, 0);

        // TRI ip=100 rise=1 fall=2
        drive(1, 0, WAVE_TRI, 100, 0, 1, 2);
        check("tri_rise", 1, 1, 0);
        for (int k = 2; k <= 100; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check("tri_rise", 16'(k), 1, 0);
        end
        for (int k = 1; k <= 50; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check("tri_fall", 16'(100 - 2 * k), k < 50, k == 50);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("tri_after", 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].wv, tbl[i].ipv, tbl[i].tn, tbl[i].rs, tbl[i].fs);
            check(tbl[i].nm, tbl[i].ei, tbl[i].eb, tbl[i].ed);
`ifdef I_SET_PULSE_CNT_EN
            if (tbl[i].cnt >= 0) begin
                n_vec++;
                if (pulse_cnt !== 32'(tbl[i].cnt)) begin
                    n_bad++;
                    $display("FAIL %s_cnt: got pulse_cnt=%0d, want %0d", tbl[i].nm, pulse_cnt, tbl[i].cnt);
                end
            end
`endif
        end

        // reset mid-profile: reset values next edge, no done pulse
        drive(1, 0, WAVE_RECT, 50, 10, 0, 0);
        check("rst_mid_run", 50, 1, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_mid", 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_mid_after", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
